line_buffer_window: RTL

LINE_BUFFER_WINDOW -- requirements
Module: line_buffer_window

---
 rtl/line_buffer_window.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/line_buffer_window.sv
// Streaming KxK window generator: K-1 line buffers feed a KxK shift array,
// and one output register presents each complete window with its centre coordinates.
module line_buffer_window #(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int PIX_W = 8,
  parameter int K     = 3
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic [PIX_W-1:0]           pixel_in,
  input  logic                       pixel_in_valid,
  output logic                       pixel_in_ready,
  input  logic                       frame_restart,
  output logic [K*K*PIX_W-1:0]       window_out,
  output logic                       window_valid,
  input  logic                       window_ready,
  output logic [$clog2(IMG_H)-1:0]   window_row,
  output logic [$clog2(IMG_W)-1:0]   window_col,
  output logic                       window_sof,
  output logic                       window_eof
);

  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int HALF = (K - 1) / 2;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_K1   = CW'(K - 1);
  localparam logic [RW-1:0] ROW_K1   = RW'(K - 1);

  typedef enum logic {FILL, RUN} state_t;

  state_t          state;
  state_t          state_eff;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col_eff;
  logic [RW-1:0]   row_eff;
  logic            accept;
  logic            produce;

  logic [PIX_W-1:0] line_mem [K-1][IMG_W];
  logic [PIX_W-1:0] win      [K][K];
  logic [PIX_W-1:0] next_win [K][K];
  logic [PIX_W-1:0] new_col  [K];
  logic [K*K*PIX_W-1:0] win_flat;

  assign pixel_in_ready = !window_valid || window_ready;
  assign accept         = pixel_in_valid && pixel_in_ready;

  // A restart pulse takes effect on the pixel accepted in the same cycle.
  always_comb begin
    col_eff   = frame_restart ? '0   : col;
    row_eff   = frame_restart ? '0   : row;
    state_eff = frame_restart ? FILL : state;
  end

  assign produce = accept && (state_eff == RUN) && (col_eff >= COL_K1);

  // NOTE: every variable in an always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      new_col[r] = line_mem[r][col_eff];
    end
    new_col[K-1] = pixel_in;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        next_win[r][c] = win[r][c+1];
      end
      next_win[r][K-1] = new_col[r];
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_flat[PIX_W*(r*K+c) +: PIX_W] = next_win[r][c];
      end
    end
  end

  // NOTE: line buffers and the window array carry no reset; stale contents are never emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < K - 1; i++) begin
        line_mem[i][col_eff] <= new_col[i+1];
      end
      win <= next_win;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      col          <= '0;
      row          <= '0;
      state        <= FILL;
      window_valid <= 1'b0;
      window_out   <= '0;
      window_row   <= '0;
      window_col   <= '0;
      window_sof   <= 1'b0;
      window_eof   <= 1'b0;
    end else begin
      if (frame_restart) begin
        col   <= '0;
        row   <= '0;
        state <= FILL;
      end
      if (accept) begin
        if (col_eff == COL_LAST) begin
          col <= '0;
          row <= (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
        end else begin
          col <= col_eff + CW'(1);
          row <= row_eff;
        end
        if (state_eff == FILL && row_eff == ROW_K1) begin
          state <= RUN;
        end else if (state_eff == RUN && row_eff == ROW_LAST && col_eff == COL_LAST) begin
          state <= FILL;
        end else begin
          state <= state_eff;
        end
      end
      // A pending window is only replaced by a new one or cleared once consumed.
      if (produce) begin
        window_valid <= 1'b1;
        window_out   <= win_flat;
        window_row   <= row_eff - RW'(HALF);
        window_col   <= col_eff - CW'(HALF);
        window_sof   <= (row_eff == ROW_K1) && (col_eff == COL_K1);
        window_eof   <= (row_eff == ROW_LAST) && (col_eff == COL_LAST);
      end else if (window_ready) begin
        window_valid <= 1'b0;
        window_sof   <= 1'b0;
        window_eof   <= 1'b0;
      end
    end
  end

endmodule
